// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : Single-outstanding load/store unit with lane steering and load
//            sign/zero extension; stalls execute while a transaction is open.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  instr_opcode_DE,
    input  logic [2:0]  funct3_DE,
    input  logic [31:0] alu_addr,
    input  logic [31:0] store_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        lsu_stall,
    output logic        misaligned
);

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_load_data;

    logic        w_is_load_in;
    logic        w_is_store_in;
    logic        w_mis_in;
    logic        w_issue;
    logic        w_r_is_load;
    logic        w_sel_store;
    logic [2:0]  w_sel_funct3;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_data;
    logic [3:0]  w_lane_mask;
    logic [31:0] w_lane_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_fmt;

    // Decode of the instruction currently presented by the execute stage
    always_comb begin
        w_is_load_in  = 1'b0;
        w_is_store_in = 1'b0;
        if (instr_opcode_DE == c_OP_LOAD) begin
            w_is_load_in = (funct3_DE == 3'b000) || (funct3_DE == 3'b001) ||
                           (funct3_DE == 3'b010) || (funct3_DE == 3'b100) ||
                           (funct3_DE == 3'b101);
        end
        if (instr_opcode_DE == c_OP_STORE) begin
            w_is_store_in = (funct3_DE == 3'b000) || (funct3_DE == 3'b001) ||
                            (funct3_DE == 3'b010);
        end
        w_mis_in = ((funct3_DE[1:0] == 2'b01) && alu_addr[0]) ||
                   ((funct3_DE[1:0] == 2'b10) && (alu_addr[1:0] != 2'b00));
    end

    assign w_issue     = (r_state == S_IDLE) && (w_is_load_in || w_is_store_in) && !w_mis_in;
    assign w_r_is_load = (r_opcode == c_OP_LOAD);

    // The first request cycle comes straight from execute; retries replay the capture
    always_comb begin
        if (r_state == S_IDLE) begin
            w_sel_store  = w_is_store_in;
            w_sel_funct3 = funct3_DE;
            w_sel_addr   = alu_addr;
            w_sel_data   = store_data;
        end else begin
            w_sel_store  = (r_opcode == c_OP_STORE);
            w_sel_funct3 = r_funct3;
            w_sel_addr   = r_addr;
            w_sel_data   = r_wdata;
        end
    end

    always_comb begin
        w_lane_mask = 4'b0000;
        w_lane_data = 32'd0;
        case (w_sel_funct3[1:0])
            2'b00: begin
                w_lane_mask = 4'b0001 << w_sel_addr[1:0];
                w_lane_data = {4{w_sel_data[7:0]}};
            end
            2'b01: begin
                w_lane_mask = 4'b0011 << w_sel_addr[1:0];
                w_lane_data = {2{w_sel_data[15:0]}};
            end
            2'b10: begin
                w_lane_mask = 4'b1111;
                w_lane_data = w_sel_data;
            end
            default: begin
                w_lane_mask = 4'b0000;
                w_lane_data = 32'd0;
            end
        endcase
    end

    assign mem_req_valid = w_issue || (r_state == S_REQ);
    assign mem_we        = mem_req_valid && w_sel_store;
    assign mem_addr      = {w_sel_addr[31:2], 2'b00};
    assign mem_wmask     = mem_we ? w_lane_mask : 4'b0000;
    assign mem_wdata     = mem_we ? w_lane_data : 32'd0;
    assign lsu_stall     = w_issue || (r_state == S_REQ) || (r_state == S_WAIT);
    assign misaligned    = (r_state == S_IDLE) && (w_is_load_in || w_is_store_in) && w_mis_in;
    assign load_valid    = (r_state == S_DONE) && w_r_is_load;
    assign load_data     = r_load_data;

    // Response lane extraction uses the address captured at issue time
    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_byte = mem_rdata[7:0];
            2'b01:   w_byte = mem_rdata[15:8];
            2'b10:   w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_fmt = {24'd0, w_byte};
            3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
            3'b101:  w_fmt = {16'd0, w_half};
            default: w_fmt = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_opcode    <= 7'd0;
            r_funct3    <= 3'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_load_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_opcode <= instr_opcode_DE;
                        r_funct3 <= funct3_DE;
                        r_addr   <= alu_addr;
                        r_wdata  <= store_data;
                        if (mem_req_ready)
                            r_state <= w_is_load_in ? S_WAIT : S_DONE;
                        else
                            r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready)
                        r_state <= w_r_is_load ? S_WAIT : S_DONE;
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_load_data <= w_fmt;
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    // DONE releases the pipeline without looking at execute again
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
